// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: picks one completed reservation station
// per cycle and drives a registered selection/sel_load/grant triple.
module cdb_arbiter #(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned ID_BASE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] complete,
    input  logic               stall,
    input  logic               flush,
    output logic [31:0]        selection,
    output logic               sel_load,
    output logic [NUM_REQ-1:0] grant
);

    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned LAST_IX = NUM_REQ - 1;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [31:0]        selection_nxt;
    logic               sel_load_nxt;
    logic [NUM_REQ-1:0] grant_nxt;

    logic [NUM_REQ-1:0] elig;
    logic               pick_vld;
    logic [PTR_W-1:0]   pick_idx;

    // The station currently broadcasting still shows complete; keep it out of the race.
    assign elig = complete & ~grant;

    // First eligible requester scanning from ptr upward with wrap-around.
    always_comb begin
        int unsigned pos;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!pick_vld && elig[PTR_W'(pos)]) begin
                pick_vld = 1'b1;
                pick_idx = PTR_W'(pos);
            end
        end
    end

    // Next-state and next-output selection; flush outranks stall, stall outranks a pick.
    always_comb begin
        ptr_nxt       = ptr;
        selection_nxt = '0;
        sel_load_nxt  = 1'b0;
        grant_nxt     = '0;
        if (flush) begin
            ptr_nxt = '0;
        end else if (!stall && pick_vld) begin
            selection_nxt       = ID_BASE + 32'(pick_idx);
            sel_load_nxt        = 1'b1;
            grant_nxt[pick_idx] = 1'b1;
            if (32'(pick_idx) == LAST_IX) begin
                ptr_nxt = '0;
            end else begin
                ptr_nxt = PTR_W'(32'(pick_idx) + 32'd1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            selection <= '0;
            sel_load  <= 1'b0;
            grant     <= '0;
        end else begin
            ptr       <= ptr_nxt;
            selection <= selection_nxt;
            sel_load  <= sel_load_nxt;
            grant     <= grant_nxt;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single requester, full rotation,
// pointer wrap, stall, flush and reset in the middle of a grant.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  complete;
    logic        stall;
    logic        flush;
    logic [31:0] selection;
    logic        sel_load;
    logic [7:0]  grant;

    int errors = 0;
    int checks = 0;

    cdb_arbiter #(.NUM_REQ(8), .ID_BASE(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .complete  (complete),
        .stall     (stall),
        .flush     (flush),
        .selection (selection),
        .sel_load  (sel_load),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    // Advance one cycle and settle just past the rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++; if (selection !== 32'd0) begin errors++; $display("FAIL reset_selection got=%0d exp=0", selection); end
        checks++; if (sel_load !== 1'b0) begin errors++; $display("FAIL reset_sel_load got=%b exp=0", sel_load); end
        checks++; if (grant !== 8'h00) begin errors++; $display("FAIL reset_grant got=%h exp=00", grant); end
        checks++; if (dut.ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr); end
    endtask

    task automatic test_single_requester;
        complete = 8'b0000_0100;
        step;
        checks++; if (selection !== 32'd3 || sel_load !== 1'b1) begin errors++; $display("FAIL single_first got=%0d/%b exp=3/1", selection, sel_load); end
        checks++; if (grant !== 8'h04) begin errors++; $display("FAIL single_grant got=%h exp=04", grant); end
        step;
        checks++; if (selection !== 32'd0 || sel_load !== 1'b0 || grant !== 8'h00) begin errors++; $display("FAIL single_masked got=%0d/%b/%h exp=0/0/00", selection, sel_load, grant); end
        step;
        checks++; if (selection !== 32'd3 || sel_load !== 1'b1) begin errors++; $display("FAIL single_rerequest got=%0d/%b exp=3/1", selection, sel_load); end
        complete = 8'h00;
        step;
        checks++; if (sel_load !== 1'b0 || dut.ptr !== 3'd3) begin errors++; $display("FAIL single_idle got=%b ptr=%0d exp=0 ptr=3", sel_load, dut.ptr); end
    endtask

    task automatic test_round_robin;
        flush = 1'b1;
        step;
        flush = 1'b0;
        complete = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step;
            checks++;
            if (selection !== 32'((k % 8) + 1) || sel_load !== 1'b1 || grant !== 8'(1 << (k % 8))) begin
                errors++;
                $display("FAIL rr_order k=%0d got=%0d/%b/%h exp=%0d/1/%h", k, selection, sel_load, grant, (k % 8) + 1, 8'(1 << (k % 8)));
            end
        end
        complete = 8'h00;
        step;
        checks++; if (sel_load !== 1'b0 || dut.ptr !== 3'd1) begin errors++; $display("FAIL rr_end got=%b ptr=%0d exp=0 ptr=1", sel_load, dut.ptr); end
    endtask

    task automatic test_wrap;
        complete = 8'h40;
        step;
        checks++; if (selection !== 32'd7 || dut.ptr !== 3'd7) begin errors++; $display("FAIL wrap_setup got=%0d ptr=%0d exp=7 ptr=7", selection, dut.ptr); end
        complete = 8'hC1;
        step;
        checks++; if (selection !== 32'd8 || grant !== 8'h80) begin errors++; $display("FAIL wrap_last got=%0d/%h exp=8/80", selection, grant); end
        checks++; if (dut.ptr !== 3'd0) begin errors++; $display("FAIL wrap_ptr got=%0d exp=0", dut.ptr); end
        complete = 8'h81;
        step;
        checks++; if (selection !== 32'd1 || grant !== 8'h01) begin errors++; $display("FAIL wrap_first got=%0d/%h exp=1/01", selection, grant); end
        complete = 8'h00;
        step;
    endtask

    task automatic test_stall;
        complete = 8'h0F;
        stall    = 1'b1;
        step;
        checks++; if (sel_load !== 1'b0 || selection !== 32'd0) begin errors++; $display("FAIL stall_c1 got=%b/%0d exp=0/0", sel_load, selection); end
        step;
        checks++; if (sel_load !== 1'b0) begin errors++; $display("FAIL stall_c2 got=%b exp=0", sel_load); end
        checks++; if (dut.ptr !== 3'd1) begin errors++; $display("FAIL stall_ptr got=%0d exp=1", dut.ptr); end
        stall = 1'b0;
        step;
        checks++; if (selection !== 32'd2 || sel_load !== 1'b1) begin errors++; $display("FAIL stall_resume got=%0d/%b exp=2/1", selection, sel_load); end
        stall = 1'b1;
        #1;
        checks++; if (selection !== 32'd2 || sel_load !== 1'b1) begin errors++; $display("FAIL stall_nocancel got=%0d/%b exp=2/1", selection, sel_load); end
        step;
        checks++; if (sel_load !== 1'b0 || dut.ptr !== 3'd2) begin errors++; $display("FAIL stall_idle got=%b ptr=%0d exp=0 ptr=2", sel_load, dut.ptr); end
        stall    = 1'b0;
        complete = 8'h00;
        step;
    endtask

    task automatic test_flush;
        complete = 8'h10;
        step;
        checks++; if (selection !== 32'd5 || dut.ptr !== 3'd5) begin errors++; $display("FAIL flush_setup got=%0d ptr=%0d exp=5 ptr=5", selection, dut.ptr); end
        complete = 8'h30;
        flush    = 1'b1;
        stall    = 1'b1;
        step;
        checks++; if (sel_load !== 1'b0 || grant !== 8'h00) begin errors++; $display("FAIL flush_idle got=%b/%h exp=0/00", sel_load, grant); end
        checks++; if (dut.ptr !== 3'd0) begin errors++; $display("FAIL flush_ptr got=%0d exp=0", dut.ptr); end
        flush = 1'b0;
        stall = 1'b0;
        step;
        checks++; if (selection !== 32'd5 || grant !== 8'h10) begin errors++; $display("FAIL flush_after got=%0d/%h exp=5/10", selection, grant); end
        complete = 8'h00;
        step;
    endtask

    task automatic test_back_to_back;
        complete = 8'h06;
        step;
        checks++; if (selection !== 32'd2) begin errors++; $display("FAIL b2b_a got=%0d exp=2", selection); end
        complete = 8'h04;
        step;
        checks++; if (selection !== 32'd3) begin errors++; $display("FAIL b2b_b got=%0d exp=3", selection); end
        complete = 8'h00;
        step;
        checks++; if (sel_load !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", sel_load); end
    endtask

    task automatic test_reset_mid_grant;
        complete = 8'hFF;
        step;
        checks++; if (selection !== 32'd4 || sel_load !== 1'b1) begin errors++; $display("FAIL rmid_setup got=%0d/%b exp=4/1", selection, sel_load); end
        reset = 1'b1;
        #1;
        checks++; if (selection !== 32'd0 || sel_load !== 1'b0 || grant !== 8'h00) begin errors++; $display("FAIL rmid_async got=%0d/%b/%h exp=0/0/00", selection, sel_load, grant); end
        step;
        reset = 1'b0;
        step;
        checks++; if (selection !== 32'd1 || grant !== 8'h01) begin errors++; $display("FAIL rmid_restart got=%0d/%h exp=1/01", selection, grant); end
        complete = 8'h00;
        step;
    endtask

    initial begin
        reset    = 1'b1;
        complete = 8'h00;
        stall    = 1'b0;
        flush    = 1'b0;
        step;
        step;
        reset = 1'b0;
        #1;
        test_reset;
        test_single_requester;
        test_round_robin;
        test_wrap;
        test_stall;
        test_flush;
        test_back_to_back;
        test_reset_mid_grant;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
